// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: FSM state codes and EX handshake levels.
package div_pkg;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;

endpackage

// File: rtl/div.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per clock, result held
// on result_o while EX keeps start_i asserted.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dq;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W:0]   minuend;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic              go;
    logic              neg_quo;
    logic              neg_rem;
    logic              last_iter;

    // Two's-complement negate when requested; |0x80..0| stays 0x80..0, which is correct unsigned.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign go        = (start_i == DIV_START) && !annul_i;
    assign neg_quo   = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
    assign neg_rem   = signed_div_i && opdata1_i[DATA_W-1];
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    // dq holds the unconsumed dividend bits at the top and the quotient bits shifted in below.
    always_comb begin
        minuend = {rem, dq[DATA_W-1]};
        trial   = minuend - {1'b0, dvsr};
        if (trial[DATA_W]) begin
            rem_nxt = minuend[DATA_W-1:0];
            quo_nxt = {dq[DATA_W-2:0], 1'b0};
        end else begin
            rem_nxt = trial[DATA_W-1:0];
            quo_nxt = {dq[DATA_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (go) begin
                        cnt   <= '0;
                        state <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: state <= DIV_END;
                DIV_ON: begin
                    if (!go) begin
                        state <= DIV_FREE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter)
                            state <= DIV_END;
                    end
                end
                default: begin
                    if (start_i == DIV_START) begin
                        result_o <= {rem, dq};
                        ready_o  <= DIV_RESULT_READY;
                    end else begin
                        state    <= DIV_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
            endcase
        end
    end

    // Datapath registers carry no reset; the FSM decides when their contents matter.
    always_ff @(posedge clk) begin
        case (state)
            DIV_FREE: begin
                if (go) begin
                    rem  <= '0;
                    dq   <= cond_neg(opdata1_i, signed_div_i && opdata1_i[DATA_W-1]);
                    dvsr <= cond_neg(opdata2_i, signed_div_i && opdata2_i[DATA_W-1]);
                end
            end
            DIV_BYZERO: begin
                rem <= '0;
                dq  <= '0;
            end
            DIV_ON: begin
                if (go) begin
                    if (last_iter) begin
                        rem <= cond_neg(rem_nxt, neg_rem);
                        dq  <= cond_neg(quo_nxt, neg_quo);
                    end else begin
                        rem <= rem_nxt;
                        dq  <= quo_nxt;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the DIV/DIVU divider: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic        ready_q = 1'b0;

    div #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder takes the dividend's sign; divide by zero gives 0.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every rising ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ready_o && !ready_q) begin
            if (exp_q.size() == 0)
                chk("unexpected_ready", result_o, 64'hx);
            else
                chk("result", result_o, exp_q.pop_front());
        end
        ready_q = ready_o;
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [63:0] exp);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        if (push) exp_q.push_back(exp);
    endtask

    // Counts falling edges from issue until ready_o; E33 completion is seen on the 34th.
    task automatic wait_ready(input int exp_n, input logic [63:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 60);
        chk("latency", 64'(n), 64'(exp_n));
        @(negedge clk);
        chk("hold_ready", {63'd0, ready_o}, 64'd1);
        chk("hold_result", result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        issue(s, a, b, 1'b1, exp);
        wait_ready((b == 32'd0) ? 3 : 34, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [31:0] a, b;
        logic        seen;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values with hand-derived expectations
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        run_div(1'b0, 32'd5, 32'd0, 64'd0);
        run_div(1'b1, 32'd5, 32'd0, 64'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        run_div(1'b1, 32'h8000_0000, 32'h8000_0000, {32'd0, 32'd1});
        run_div(1'b0, 32'd3, 32'hFFFF_FFFF, {32'd3, 32'd0});

        // Annul on E10, then a new 9/4 accepted on the very next edge
        issue(1'b0, 32'd1000, 32'd3, 1'b0, 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= ready_o;
        end
        annul_i = 1'b1;
        @(negedge clk);
        seen |= ready_o;
        chk("annul_no_ready", {63'd0, seen}, 64'd0);
        issue(1'b0, 32'd9, 32'd4, 1'b1, {32'd1, 32'd2});
        wait_ready(34, {32'd1, 32'd2});

        // start_i dropped on E15: operation abandoned, no ready
        issue(1'b1, 32'd3000, 32'd11, 1'b0, 64'd0);
        repeat (15) @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= ready_o;
        end
        chk("stop_no_ready", {63'd0, seen}, 64'd0);

        // Reset on E20 mid-division
        issue(1'b0, 32'd2000, 32'd7, 1'b0, 64'd0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= ready_o;
        end
        chk("rst_mid_quiet", {63'd0, seen}, 64'd0);

        // Reset while the result is being presented
        issue(1'b0, 32'd40, 32'd6, 1'b1, {32'd4, 32'd6});
        repeat (36) @(negedge clk);
        chk("pre_rst_ready", {63'd0, ready_o}, 64'd1);
        rst = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Random operands against the reference model
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            run_div(s, a, b, ref_div(s, a, b));
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
